vehicle_request_unit: RTL and testbench
=======================================

VEHICLE_REQUEST_UNIT -- requirements
Module: vehicle_request_unit

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4, number of consecutive synchronized-high cycles before a detector is accepted as a request (legal range 1..15).
REQ-002 Parameter STARVE_CYC, default 255, pending-wait threshold in cycles for the starvation flag (legal range 1..255).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 det  input  4  raw loop-detector level per lane, bit i = lane i+1, asynchronous to clk.
REQ-006 Gi  input  4  one-hot green lamp feedback from the light controller, bit i = lane i+1.
REQ-007 T1, T2, T3, T4  output  1 each  registered per-lane traffic request to the light controller.
REQ-008 req_any  output  1  OR of T1..T4, combinational from the registered requests.
REQ-009 starve  output  4  registered per-lane starvation flag.

Function
REQ-010 Each det bit SHALL pass a two-flop synchronizer; det_s denotes the second-stage output.
REQ-011 Each lane SHALL run an independent FSM with states IDLE, ARM, PENDING, SERVED and a 4-bit debounce counter cnt.
REQ-012 IDLE: det_s=1 -> ARM with cnt=1; otherwise stay IDLE.
REQ-013 ARM: det_s=0 -> IDLE with cnt=0; det_s=1 and cnt==DEBOUNCE_CYC-1 -> PENDING; otherwise cnt increments.
REQ-014 If DEBOUNCE_CYC=1, IDLE SHALL go directly to PENDING when det_s=1.
REQ-015 The lane request SHALL assert on the (DEBOUNCE_CYC+2)th rising edge after det is first sampled high, provided det holds high throughout.
REQ-016 PENDING: the request is latched; it SHALL stay 1 even if det_s drops.
REQ-017 PENDING leaves only via Gi[i]=1 -> SERVED.
REQ-018 SERVED: the request output SHALL equal det_s registered, reporting live occupancy so an empty lane does not hold green.
REQ-019 SERVED exit, on Gi[i]=0: det_s=1 -> PENDING with request 1; det_s=0 -> IDLE with request 0.
REQ-020 Gi[i]=1 in IDLE or ARM SHALL force SERVED, clearing cnt.
REQ-021 Gi[i]=1 takes priority over debounce completion in the same cycle.
REQ-022 Gi with more than one bit set SHALL be treated per lane independently; no error is raised.
REQ-023 req_any SHALL be 1 in any cycle where at least one lane request is 1.

Reset
REQ-024 While reset=1 at a clock edge, every lane SHALL enter IDLE, with cnt=0, synchronizer flops 0, T1..T4=0, starve=0 and wait counters 0.
REQ-025 Reset asserted mid-debounce or mid-service SHALL discard all pending requests without retention.

Configuration
REQ-026 With macro VEHICLE_REQUEST_WAIT_STATS_EN defined, each lane SHALL carry an 8-bit wait counter.
REQ-027 The wait counter SHALL increment every cycle in PENDING, saturate at STARVE_CYC, and clear on entry to SERVED.
REQ-028 With the macro defined, starve[i] SHALL be 1 whenever the lane's counter equals STARVE_CYC.
REQ-029 Without the macro, the wait counters SHALL not exist, and starve SHALL be constant 0 with the port still present.

Structure
REQ-030 A shared package SHALL hold the lane state enum (IDLE, ARM, PENDING, SERVED), the lane count constant 4, and the counter width constants.
REQ-031 The per-lane synchronizer, FSM, debounce counter and optional wait counter SHALL form sub-module lane_request_fsm, instantiated 4 times.
REQ-032 The top level SHALL only instantiate the lanes, map outputs to T1..T4 and form req_any.

Verification
REQ-033 Scenario, debounce: DEBOUNCE_CYC=4, det[0] held high from cycle 0 -> T1 rises after edge 6, req_any=1 in the same cycle.
REQ-034 Scenario, glitch rejection: det[1] high for 3 cycles then low -> T2 stays 0 and the lane returns to IDLE.
REQ-035 Scenario, latch and serve: T3 pending, det[2] dropped, Gi=4'b0100 for 10 cycles then 0 -> T3=0 in SERVED, then IDLE.
REQ-036 Scenario, re-request after green: T4 pending, det[3] held high through a green window -> T4 stays 1 after Gi[3] falls (PENDING).
REQ-037 Scenario, starvation with macro defined: STARVE_CYC=20, T1 pending, no green -> starve[0]=1 after 20 PENDING cycles, cleared when Gi[0] rises; without macro, starve=0.
REQ-038 Scenario, reset mid-operation: reset pulsed for 1 cycle with all lanes PENDING -> T1..T4=0 and starve=0 on the next edge.

Source files
------------

// File: rtl/vehicle_request_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vehicle_request_unit_pkg
// Description : Shared types and constants for the vehicle request unit:
//               lane state encoding, lane count and counter widths.
// Revision    : 1.0 - initial release
// ============================================================================
package vehicle_request_unit_pkg;

  // Number of approach lanes served by the unit
  localparam int c_LANES  = 4;

  // Debounce counter width (supports thresholds 1..15)
  localparam int c_CNT_W  = 4;

  // Wait counter width (supports starvation thresholds 1..255)
  localparam int c_WAIT_W = 8;

  // Per-lane request state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_PENDING = 2'd2,
    ST_SERVED  = 2'd3
  } lane_state_t;

endpackage : vehicle_request_unit_pkg
`default_nettype wire

// File: rtl/vehicle_request_unit_lane.sv
`default_nettype none
// ============================================================================
// Module      : lane_request_fsm
// Description : One traffic lane: two-flop detector synchronizer, debounce
//               state machine, latched request and, when the macro
//               VEHICLE_REQUEST_WAIT_STATS_EN is defined, a saturating wait
//               counter driving the starvation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_request_fsm
  import vehicle_request_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int STARVE_CYC   = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic i_det,
  input  logic i_green,
  output logic o_req,
  output logic o_starve
);

  // Last debounce count value before the request is accepted
  localparam logic [c_CNT_W-1:0] c_DEB_LAST = c_CNT_W'(DEBOUNCE_CYC - 1);

  logic              r_sync1;
  logic              r_sync2;
  lane_state_t       r_state;
  lane_state_t       w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic              r_req;
  logic              w_req_nxt;

  // Bring the asynchronous loop-detector level into the clock domain
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_det;
      r_sync2 <= r_sync1;
    end
  end

  // State, debounce count and request register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  // Next state: green always wins over debounce completion
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_green) begin
          w_state_nxt = ST_SERVED;
          w_cnt_nxt   = '0;
        end else if (r_sync2) begin
          if (DEBOUNCE_CYC == 1) begin
            w_state_nxt = ST_PENDING;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_ARM;
            w_cnt_nxt   = c_CNT_W'(1);
          end
        end
      end
      ST_ARM: begin
        if (i_green) begin
          w_state_nxt = ST_SERVED;
          w_cnt_nxt   = '0;
        end else if (!r_sync2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_DEB_LAST) begin
          w_state_nxt = ST_PENDING;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_W'(1);
        end
      end
      ST_PENDING: begin
        if (i_green) begin
          w_state_nxt = ST_SERVED;
        end
      end
      ST_SERVED: begin
        if (!i_green) begin
          w_state_nxt = r_sync2 ? ST_PENDING : ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // Pending holds the request; while served it tracks live occupancy
    w_req_nxt = (w_state_nxt == ST_PENDING) ||
                ((w_state_nxt == ST_SERVED) && r_sync2);
  end

  assign o_req = r_req;

`ifdef VEHICLE_REQUEST_WAIT_STATS_EN
  localparam logic [c_WAIT_W-1:0] c_STARVE = c_WAIT_W'(STARVE_CYC);

  logic [c_WAIT_W-1:0] r_wait;
  logic [c_WAIT_W-1:0] w_wait_nxt;
  logic                r_starve;

  // Wait counter: counts pending cycles, saturates, clears on service
  always_comb begin
    w_wait_nxt = r_wait;
    if (w_state_nxt == ST_SERVED) begin
      w_wait_nxt = '0;
    end else if ((r_state == ST_PENDING) && (r_wait != c_STARVE)) begin
      w_wait_nxt = r_wait + c_WAIT_W'(1);
    end
  end

  // Wait counter and starvation flag registers (flag mirrors counter==threshold)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait   <= '0;
      r_starve <= 1'b0;
    end else begin
      r_wait   <= w_wait_nxt;
      r_starve <= (w_wait_nxt == c_STARVE);
    end
  end

  assign o_starve = r_starve;
`else
  // Statistics compiled out: the flag is always 0; the threshold is still
  // referenced so the parameter is consumed in this build.
  assign o_starve = 1'b0 && (STARVE_CYC != 0);
`endif

endmodule : lane_request_fsm
`default_nettype wire

// File: rtl/vehicle_request_unit.sv
`default_nettype none
// ============================================================================
// Module      : vehicle_request_unit
// Description : Four-lane vehicle request unit. Instantiates one
//               lane_request_fsm per lane, maps the requests to T1..T4 and
//               forms req_any. Optional wait statistics are enabled with the
//               macro VEHICLE_REQUEST_WAIT_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vehicle_request_unit
  import vehicle_request_unit_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int STARVE_CYC   = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [c_LANES-1:0]  det,
  input  logic [c_LANES-1:0]  Gi,
  output logic                T1,
  output logic                T2,
  output logic                T3,
  output logic                T4,
  output logic                req_any,
  output logic [c_LANES-1:0]  starve
);

  logic [c_LANES-1:0] w_req;
  logic [c_LANES-1:0] w_starve;

  for (genvar gi = 0; gi < c_LANES; gi++) begin : g_lane
    lane_request_fsm #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .STARVE_CYC   (STARVE_CYC)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .i_det    (det[gi]),
      .i_green  (Gi[gi]),
      .o_req    (w_req[gi]),
      .o_starve (w_starve[gi])
    );
  end

  assign T1      = w_req[0];
  assign T2      = w_req[1];
  assign T3      = w_req[2];
  assign T4      = w_req[3];
  assign req_any = |w_req;
  assign starve  = w_starve;

endmodule : vehicle_request_unit
`default_nettype wire

// File: tb/tb_vehicle_request_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_vehicle_request_unit
// Description : Scoreboard bench for vehicle_request_unit. Directed scenario
//               phase followed by randomized detector/green traffic; a lane
//               reference model pushes expected outputs each edge and a
//               monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vehicle_request_unit;

  localparam int DEB  = 4;
  localparam int STV  = 20;
  localparam int NCYC = 2400;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] det;
  logic [3:0] Gi;
  logic       T1, T2, T3, T4;
  logic       req_any;
  logic [3:0] starve;

  always #5 clk = ~clk;

  vehicle_request_unit #(
    .DEBOUNCE_CYC (DEB),
    .STARVE_CYC   (STV)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .det     (det),
    .Gi      (Gi),
    .T1      (T1),
    .T2      (T2),
    .T3      (T3),
    .T4      (T4),
    .req_any (req_any),
    .starve  (starve)
  );

  typedef struct packed {
    logic [3:0] t;
    logic       any;
    logic [3:0] st;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: mode 0 = waiting for vehicle, 1 = latched, 2 = green.
  // run = consecutive synchronized-high cycles seen while waiting.
  int         m_mode[4];
  int         m_run[4];
  int         m_wait[4];
  logic [3:0] m_s1, m_s2;

  task automatic model_step();
    exp_t       e;
    logic [3:0] ds;
    int         old;
    e  = '0;
    ds = m_s2;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_mode[i] = 0; m_run[i] = 0; m_wait[i] = 0;
      end
      m_s1 = 4'b0;
      m_s2 = 4'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        old = m_mode[i];
        if (old == 0) begin
          if (Gi[i]) begin
            m_mode[i] = 2; m_run[i] = 0;
          end else if (ds[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] >= DEB) begin
              m_mode[i] = 1; m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end else if (old == 1) begin
          if (Gi[i]) m_mode[i] = 2;
        end else begin
          if (!Gi[i]) m_mode[i] = ds[i] ? 1 : 0;
        end
        if (m_mode[i] == 2) m_wait[i] = 0;
        else if (old == 1 && m_wait[i] < STV) m_wait[i] = m_wait[i] + 1;
        e.t[i] = (m_mode[i] == 1) || (m_mode[i] == 2 && ds[i]);
`ifdef VEHICLE_REQUEST_WAIT_STATS_EN
        e.st[i] = (m_wait[i] == STV);
`else
        e.st[i] = 1'b0;
`endif
      end
      m_s2 = m_s1;
      m_s1 = det;
    end
    e.any = |e.t;
    q.push_back(e);
  endtask

  int         g_hold = 0;
  logic [3:0] g_val  = 4'b0;

  // Directed scenarios for the first cycles, random traffic afterwards
  task automatic apply(input int c);
    if (c < 105) begin
      reset = (c < 3) || (c == 100);
      det   = 4'b0;
      Gi    = 4'b0;
      if (c >= 3  && c < 70)  det[0] = 1'b1;
      if (c >= 10 && c <= 12) det[1] = 1'b1;
      if (c >= 15 && c <= 24) det[2] = 1'b1;
      if (c >= 30 && c < 70)  det[3] = 1'b1;
      if (c >= 75 && c < 100) det    = 4'hF;
      if (c >= 35 && c <= 44) Gi[2]  = 1'b1;
      if (c >= 50 && c <= 55) Gi[3]  = 1'b1;
      if (c >= 60 && c <= 63) Gi[0]  = 1'b1;
    end else begin
      reset = ($urandom_range(399) == 0);
      for (int i = 0; i < 4; i++)
        if ($urandom_range(6) == 0) det[i] = ~det[i];
      if (g_hold == 0) begin
        g_hold = $urandom_range(14, 1);
        if ($urandom_range(1) == 0) g_val = 4'b0;
        else if ($urandom_range(3) == 0) g_val = 4'($urandom_range(15));
        else g_val = 4'(1 << $urandom_range(3));
      end
      g_hold = g_hold - 1;
      Gi = g_val;
    end
  endtask

  task automatic driver();
    for (int c = 0; c < NCYC; c++) begin
      apply(c);
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  task automatic monitor();
    exp_t       e;
    logic [3:0] t;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      t = {T4, T3, T2, T1};
      checks = checks + 1;
      if (q.size() == 0) begin
        failures = failures + 1;
        $display("FAIL scoreboard_empty cycle=%0d", c);
      end else begin
        e = q.pop_front();
        if (t !== e.t) begin
          failures = failures + 1;
          $display("FAIL T cycle=%0d actual=%b required=%b", c, t, e.t);
        end
        checks = checks + 1;
        if (req_any !== e.any) begin
          failures = failures + 1;
          $display("FAIL req_any cycle=%0d actual=%b required=%b", c, req_any, e.any);
        end
        checks = checks + 1;
        if (starve !== e.st) begin
          failures = failures + 1;
          $display("FAIL starve cycle=%0d actual=%b required=%b", c, starve, e.st);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    det   = 4'b0;
    Gi    = 4'b0;
    m_s1  = 4'b0;
    m_s2  = 4'b0;
    for (int i = 0; i < 4; i++) begin
      m_mode[i] = 0; m_run[i] = 0; m_wait[i] = 0;
    end
    fork
      driver();
      monitor();
    join
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_vehicle_request_unit
`default_nettype wire
